// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_HALT     = 4'd11
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/rv_multicycle_ctrl_alu_decoder.sv
// ALU operation decode for R-type and I-type arithmetic; valid_o flags
// funct3 values this core does not implement.
module rv_alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_rtype_i,
  output logic [3:0] alu_control_o,
  output logic       valid_o
);

  // funct3 to ALU operation; SUB only exists for R-type.
  always_comb begin
    alu_control_o = ALU_ADD;
    valid_o       = 1'b0;
    case (funct3_i)
      3'b000: begin
        valid_o = 1'b1;
        if (is_rtype_i && funct7b5_i) begin
          alu_control_o = ALU_SUB;
        end else begin
          alu_control_o = ALU_ADD;
        end
      end
      3'b010: begin
        valid_o       = 1'b1;
        alu_control_o = ALU_SLT;
      end
      3'b110: begin
        valid_o       = 1'b1;
        alu_control_o = ALU_OR;
      end
      3'b111: begin
        valid_o       = 1'b1;
        alu_control_o = ALU_AND;
      end
      default: begin
        valid_o       = 1'b0;
        alu_control_o = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core.
// Define RV_CTRL_FULL_BRANCH_EN for BLT/BGE/BLTU/BGEU; otherwise only BEQ/BNE.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter bit RESET_STATE_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  input  logic       carry,
  input  logic       overflow,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);

  localparam state_e RESET_STATE = RESET_STATE_HALT ? S_HALT : S_FETCH;

  state_e     state_q;
  state_e     state_d;

  logic [3:0] dec_alu_s;
  logic       dec_valid_s;
  logic       is_rtype_s;
  logic       full_br_s;
  logic       lt_s;
  logic       ltu_s;
  logic       br_legal_s;
  logic       br_taken_s;

  logic       pc_write_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [2:0] imm_src_s;
  logic [3:0] alu_control_s;
  logic       illegal_s;

  assign is_rtype_s = (state_q == S_EXECR);

  rv_alu_decoder u_alu_dec (
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .is_rtype_i    (is_rtype_s),
    .alu_control_o (dec_alu_s),
    .valid_o       (dec_valid_s)
  );

`ifdef RV_CTRL_FULL_BRANCH_EN
  assign full_br_s = 1'b1;
  assign lt_s      = neg ^ overflow;
  assign ltu_s     = carry;
`else
  logic [2:0] unused_flags_s;
  assign unused_flags_s = {neg, carry, overflow};
  assign full_br_s      = 1'b0;
  assign lt_s           = 1'b0;
  assign ltu_s          = 1'b0;
`endif

  // Branch condition from the flags of the rs1 - rs2 subtract.
  always_comb begin
    br_legal_s = 1'b0;
    br_taken_s = 1'b0;
    case (funct3)
      F3_BEQ: begin
        br_legal_s = 1'b1;
        br_taken_s = zero;
      end
      F3_BNE: begin
        br_legal_s = 1'b1;
        br_taken_s = ~zero;
      end
      F3_BLT: begin
        br_legal_s = full_br_s;
        br_taken_s = lt_s;
      end
      F3_BGE: begin
        br_legal_s = full_br_s;
        br_taken_s = full_br_s & ~lt_s;
      end
      F3_BLTU: begin
        br_legal_s = full_br_s;
        br_taken_s = ltu_s;
      end
      F3_BGEU: begin
        br_legal_s = full_br_s;
        br_taken_s = full_br_s & ~ltu_s;
      end
      default: begin
        br_legal_s = 1'b0;
        br_taken_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore output decode; only BRANCH adds a flag-dependent pc_write.
  always_comb begin
    state_d       = state_q;
    pc_write_s    = 1'b0;
    adr_src_s     = 1'b0;
    mem_write_s   = 1'b0;
    ir_write_s    = 1'b0;
    reg_write_s   = 1'b0;
    result_src_s  = RES_ALUOUT;
    alu_src_a_s   = SRCA_PC;
    alu_src_b_s   = SRCB_RS2;
    imm_src_s     = IMM_I;
    alu_control_s = ALU_ADD;
    illegal_s     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_s   = 1'b1;
        pc_write_s   = 1'b1;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALU;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
        imm_src_s   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = SRCA_RS1;
        alu_src_b_s = SRCB_IMM;
        if (opcode == OP_STORE) begin
          imm_src_s = IMM_S;
          state_d   = S_MEMWRITE;
        end else begin
          imm_src_s = IMM_I;
          state_d   = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a_s   = SRCA_RS1;
        alu_src_b_s   = is_rtype_s ? SRCB_RS2 : SRCB_IMM;
        alu_control_s = dec_alu_s;
        if (dec_valid_s) begin
          state_d = S_ALUWB;
        end else begin
          state_d = S_HALT;
        end
      end
      S_ALUWB: begin
        result_src_s = RES_ALUOUT;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_s  = SRCA_OLDPC;
        alu_src_b_s  = SRCB_FOUR;
        result_src_s = RES_ALUOUT;
        pc_write_s   = 1'b1;
        state_d      = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a_s   = SRCA_RS1;
        alu_src_b_s   = SRCB_RS2;
        alu_control_s = ALU_SUB;
        result_src_s  = RES_ALUOUT;
        pc_write_s    = br_legal_s & br_taken_s;
        if (br_legal_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        illegal_s = 1'b1;
        state_d   = S_HALT;
      end
      default: begin
        illegal_s = 1'b1;
        state_d   = S_HALT;
      end
    endcase
  end

  // Outputs are forced quiet for as long as rst_n is held low.
  assign pc_write    = rst_n & pc_write_s;
  assign adr_src     = rst_n & adr_src_s;
  assign mem_write   = rst_n & mem_write_s;
  assign ir_write    = rst_n & ir_write_s;
  assign reg_write   = rst_n & reg_write_s;
  assign result_src  = rst_n ? result_src_s  : 2'b00;
  assign alu_src_a   = rst_n ? alu_src_a_s   : 2'b00;
  assign alu_src_b   = rst_n ? alu_src_b_s   : 2'b00;
  assign imm_src     = rst_n ? imm_src_s     : 3'b000;
  assign alu_control = rst_n ? alu_control_s : 4'b0000;
  assign illegal     = rst_n & illegal_s;

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. It is the initiator side of the ALU interface: it drives the 4-bit ALU control code and datapath mux selects, and it consumes the ALU zero/neg/carry/overflow flags to resolve branches. It sits between the instruction register and the shared datapath, sequencing fetch, decode, execute, memory and writeback.

Parameters:
- RESET_STATE_HALT, 0, when 1 the FSM leaves reset in HALT rather than FETCH (bring-up aid).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- zero, neg, carry, overflow  in  1 each  ALU flags, same cycle as alu_control
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address: 0 = PC, 1 = ALU-out register
- mem_write  out  1  data memory write enable
- ir_write  out  1  IR and old-PC enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 = ALU-out register, 01 = data register, 10 = live ALU result
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4
- imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J
- alu_control  out  4  ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0100
- illegal  out  1  sticky; set on an undecodable instruction

Behaviour:
- Reset: asynchronous, and an edge of rst_n low mid-instruction takes the FSM straight to FETCH (HALT if RESET_STATE_HALT).
- While rst_n is low, all enables (pc_write, ir_write, mem_write, reg_write) are 0 and illegal is 0. Every other output is 0 during reset.
- Outputs are Moore-decoded from state, except pc_write in BRANCH, which is state AND branch-taken.
- FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, ADD, result_src=10, pc_write=1. Next state is DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=010, ADD. This precomputes the branch target. Next state by opcode:
  - 0000011 or 0100011 go to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI.
  - 1100011 goes to BRANCH.
  - 1101111 goes to JAL.
  - Any other opcode goes to HALT.
- MEMADR: alu_src_a=10, alu_src_b=01, ADD, imm_src 000 for lw and 001 for sw. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1, goes to MEMWB. MEMWB: result_src=01, reg_write=1, goes to FETCH.
- MEMWRITE: adr_src=1, mem_write=1, goes to FETCH.
- EXECR and EXECI: alu_src_a=10; alu_src_b is 00 (R) or 01 (I); alu_control comes from alu_decoder. Next state is ALUWB.
- ALUWB: result_src=00, reg_write=1, goes to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1. Next state is ALUWB.
- BRANCH: alu_src_a=10, alu_src_b=00, SUB, result_src=00. Taken conditions:
  - 000 BEQ: zero
  - 001 BNE: !zero
  - 100 BLT: neg^overflow
  - 101 BGE: !(neg^overflow)
  - 110 BLTU: carry (carry is the borrow of a 33-bit subtract)
  - 111 BGEU: !carry
  - 010 and 011: illegal, go to HALT.
  - Otherwise next state is FETCH.
- Instruction latencies: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; branch 3 cycles.
- alu_decoder mapping by funct3:
  - 000 gives ADD, or SUB when R-type and funct7b5=1.
  - 010 gives SLT, 110 gives OR, 111 gives AND.
  - Any other funct3 in EXECR or EXECI goes to HALT.
  - An I-type with funct3 000 ignores funct7b5.
- HALT: all enables are 0 and illegal=1. HALT is sticky until reset.
- IR fields are stable after FETCH, so mid-instruction opcode changes are not possible.

Optional Feature:
- Macro: RV_CTRL_FULL_BRANCH_EN.
- Defined: all six branch conditions as above.
- Undefined: only BEQ and BNE are supported; funct3 100, 101, 110 and 111 in BRANCH go to HALT. Carry and overflow inputs are unused.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state enum
  - ALU control localparams (ADD, SUB, AND, OR, SLT)
  - opcode constants
  - result_src, alu_src_a, alu_src_b and imm_src encodings
- One sub-module, rv_alu_decoder: combinational mapping of funct3, funct7b5 and is_rtype to alu_control plus a valid bit.

Test Plan:
- Reset mid-MEMREAD of lw: rst_n low → immediately all enables 0, illegal 0; release → FETCH with ir_write=1, pc_write=1, alu_control=0000.
- R-type sub (opcode 0110011, funct3 000, funct7b5=1) → EXECR shows alu_control=0001, ALUWB shows reg_write=1, total 4 cycles.
- lw (0000011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; MEMWB has result_src=01 and reg_write=1; 5 cycles.
- BLTU with carry=1 → pc_write=1 in BRANCH. BLTU with carry=0 → pc_write=0.
- BLT with neg=1, overflow=1 → not taken; with neg=0, overflow=1 → taken.
- Opcode 1111111, then a separate test with R-type funct3 001 → HALT, illegal=1 held for 10 cycles, enables 0; cleared only by rst_n.
